axi_ram_slave: RTL and testbench

Parametrised AXI4 memory target with independent read and write channels, serving as the main-memory model behind the core's cache/bus master in simulation and as a synthesizable on-chip RAM.

- Adds configurable data width, depth, base address and read latency.
- Adds FIXED/INCR/WRAP burst types, RREADY back-pressure and SLVERR on out-of-range beats.
- Storage is an internal array; it is not reset.

---
 rtl/axi_ram_slave.sv | 216 +++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// AXI4 memory target: independent read and write burst engines over a
// byte-strobed word array. Storage is never reset; only control state is.
module axi_ram_slave #(
  parameter int                DATA_W = 128,
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int                RD_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [ADDR_W-1:0]      ARADDR,
  input  logic [7:0]             ARLEN,
  input  logic [1:0]             ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [DATA_W-1:0]      RDATA,
  output logic [1:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic [ADDR_W-1:0]      AWADDR,
  input  logic [7:0]             AWLEN,
  input  logic [1:0]             AWBURST,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_W-1:0]      WDATA,
  input  logic [DATA_W/8-1:0]    WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ~(STEP - 1'b1);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [7:0] len,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] win;
    logic [ADDR_W-1:0] nxt;
    win = (ADDR_W'(len) + 1'b1) << OFF_W;
    nxt = a + STEP;
    if (burst == 2'b00)
      nxt = a;
    else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      nxt = (a & ~(win - 1'b1)) | ((a + STEP) & (win - 1'b1));
    return nxt;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> OFF_W) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t          r_state, r_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic [1:0]        r_burst;
  logic [3:0]        r_lat;
  logic              ar_take, r_beat, rd_ok;

  w_state_t          w_state, w_state_nx;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [1:0]        w_burst;
  logic              w_err, aw_take, w_beat, wr_ok;

  // Read channel: address accept, latency wait, beat streaming
  always_comb begin
    r_state_nx = r_state;
    ARREADY    = 1'b0;
    RVALID     = 1'b0;
    RLAST      = 1'b0;
    ar_take    = 1'b0;
    r_beat     = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) begin
          ar_take    = 1'b1;
          r_state_nx = (RD_LAT == 0) ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: if (r_lat <= 4'd1) r_state_nx = R_DATA;
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = (r_cnt == 8'd0);
        if (RREADY) begin
          r_beat = 1'b1;
          if (r_cnt == 8'd0) r_state_nx = R_IDLE;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read data comes straight from the array, so a same-cycle write is seen next cycle
  assign rd_ok = (r_state == R_DATA) && in_range(r_addr);
  assign RDATA = rd_ok ? mem[to_idx(r_addr)] : '0;
  assign RRESP = ((r_state == R_DATA) && !rd_ok) ? 2'b10 : 2'b00;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= r_state_nx;
      if (ar_take) begin
        r_cnt <= ARLEN;
        r_lat <= 4'(RD_LAT);
      end else if (r_state == R_WAIT) begin
        r_lat <= r_lat - 4'd1;
      end else if (r_beat) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (ar_take) begin
      r_addr  <= ARADDR & ALIGN;
      r_len   <= ARLEN;
      r_burst <= ARBURST;
    end else if (r_beat && r_cnt != 8'd0) begin
      r_addr  <= next_addr(r_addr, r_len, r_burst);
    end
  end

  // Write channel: address accept, strobed beats, response
  always_comb begin
    w_state_nx = w_state;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    BRESP      = 2'b00;
    aw_take    = 1'b0;
    w_beat     = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) begin
          aw_take    = 1'b1;
          w_state_nx = W_DATA;
        end
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          w_beat = 1'b1;
          if (w_cnt == 8'd0) w_state_nx = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = w_err ? 2'b10 : 2'b00;
        if (BREADY) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  assign wr_ok = in_range(w_addr);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      if (aw_take) begin
        w_cnt <= AWLEN;
        w_err <= 1'b0;
      end else if (w_beat) begin
        w_cnt <= w_cnt - 8'd1;
        if (!wr_ok || (WLAST != (w_cnt == 8'd0))) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (aw_take) begin
      w_addr  <= AWADDR & ALIGN;
      w_len   <= AWLEN;
      w_burst <= AWBURST;
    end else if (w_beat) begin
      w_addr  <= next_addr(w_addr, w_len, w_burst);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_beat && wr_ok) begin
      for (int b = 0; b < BYTES; b++)
        if (WSTRB[b]) mem[to_idx(w_addr)][b*8 +: 8] <= WDATA[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: directed and random bursts checked against a
// word-array reference model with closed-form burst address computation.
module tb_axi_ram_slave;

  localparam int          DW     = 128;
  localparam int          AW     = 32;
  localparam int          DEPTH  = 64;
  localparam int          BYTES  = DW / 8;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic [1:0]    arburst, awburst;
  logic          arvalid, arready, awvalid, awready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          rlast, rvalid, rready;
  logic [BYTES-1:0] wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] mdl [DEPTH];

  always #5 clk = ~clk;

  axi_ram_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .CLK(clk), .RSTn(rstn),
    .ARADDR(araddr), .ARLEN(arlen), .ARBURST(arburst), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready),
    .AWADDR(awaddr), .AWLEN(awlen), .AWBURST(awburst), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Address of beat i computed directly from the burst rules
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] a0, win, lo;
    a0 = start - (start % BYTES);
    if (burst == 2'b00) return a0;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      win = (32'(len) + 1) * BYTES;
      lo  = a0 - (a0 % win);
      return lo + ((a0 - lo + 32'(i * BYTES)) % win);
    end
    return a0 + 32'(i * BYTES);
  endfunction

  function automatic bit mdl_ok(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH * BYTES);
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    return int'((a - BASE) / BYTES);
  endfunction

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input bit stall, input int abort_at, output logic [DW-1:0] d0);
    int w;
    logic [31:0] a;
    logic [DW-1:0] ed, hold_d;
    logic hold_l;
    d0 = '0;
    @(negedge clk);
    araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    chk("arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w = 0;
      while (!rvalid && w < 40) begin w++; @(negedge clk); end
      if (i == 0) chk("r_first_latency", w, RD_LAT);
      else chk("r_no_bubble", w, 0);
      chk("r_valid", rvalid, 1);
      if (!rvalid) return;
      a  = beat_addr(addr, len, burst, i);
      ed = mdl_ok(a) ? mdl[mdl_idx(a)] : '0;
      chk("r_data", rdata, ed);
      chk("r_resp", rresp, mdl_ok(a) ? 2'b00 : 2'b10);
      chk("r_last", rlast, (i == int'(len)));
      if (i == 0) d0 = rdata;
      if (i == abort_at) return;
      if (stall) begin
        hold_d = rdata; hold_l = rlast;
        repeat (2) begin
          @(negedge clk);
          chk("r_stall_valid", rvalid, 1);
          chk("r_stall_data", rdata, hold_d);
          chk("r_stall_last", rlast, hold_l);
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
    chk("r_end_arready", arready, 1);
    chk("r_end_rvalid", rvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [DW-1:0] dat, input bit drnd, input logic [BYTES-1:0] strb,
                          input bit srnd, input int last_at);
    logic err;
    logic [31:0] a;
    logic [DW-1:0] d;
    logic [BYTES-1:0] s;
    err = 1'b0;
    @(negedge clk);
    awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    chk("awready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      d = drnd ? {$urandom, $urandom, $urandom, $urandom} : dat;
      s = srnd ? BYTES'($urandom) : strb;
      wdata = d; wstrb = s; wlast = (i == last_at); wvalid = 1'b1;
      chk("wready", wready, 1);
      a = beat_addr(addr, len, burst, i);
      if (mdl_ok(a)) begin
        for (int b = 0; b < BYTES; b++)
          if (s[b]) mdl[mdl_idx(a)][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        err = 1'b1;
      end
      if ((i == last_at) != (i == int'(len))) err = 1'b1;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done_awready", awready, 1);
    chk("b_done_bvalid", bvalid, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rlast"}, rlast, 0);
    chk({tag, "_rresp"}, rresp, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_bresp"}, bresp, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    logic [31:0] a;
    logic [7:0]  len;
    logic [1:0]  bt;
    rstn = 1'b0;
    araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;

    // Fill the whole array so every read has a known expectation
    do_write(BASE, 8'(DEPTH - 1), 2'b01, '0, 1'b1, '1, 1'b0, DEPTH - 1);

    // Single full-strobe INCR beat
    do_write(BASE + 32'h20, 8'd0, 2'b01, 128'h00112233445566778899AABBCCDDEEFF, 1'b0, '1, 1'b0, 0);
    do_read(BASE + 32'h20, 8'd0, 2'b01, 1'b0, -1, d);
    chk("single_beat_data", d, 128'h00112233445566778899AABBCCDDEEFF);

    // Partial strobe over a known background
    do_write(BASE + 32'h40, 8'd0, 2'b01, {16{8'hAA}}, 1'b0, '1, 1'b0, 0);
    do_write(BASE + 32'h40, 8'd0, 2'b01, {16{8'h55}}, 1'b0, 16'h000F, 1'b0, 0);
    do_read(BASE + 32'h40, 8'd0, 2'b01, 1'b0, -1, d);
    chk("partial_strobe_data", d, {{12{8'hAA}}, {4{8'h55}}});

    // WRAP read starting at word 3 of a 4-word window
    do_read(BASE + 32'h30, 8'd3, 2'b10, 1'b0, -1, d);
    chk("wrap_first_word3", d, mdl[3]);

    // Out of range at the top, at the bottom, and on write
    do_read(BASE + DEPTH * BYTES - BYTES, 8'd1, 2'b01, 1'b0, -1, d);
    do_write(BASE + DEPTH * BYTES - BYTES, 8'd1, 2'b01, '0, 1'b1, '1, 1'b0, 1);
    do_read(BASE + DEPTH * BYTES - BYTES, 8'd0, 2'b01, 1'b0, -1, d);
    do_read(BASE - BYTES, 8'd1, 2'b01, 1'b0, -1, d);

    // FIXED bursts, unaligned WRAP, illegal-length WRAP and type 11
    do_write(BASE + 32'h50, 8'd3, 2'b00, '0, 1'b1, '0, 1'b1, 3);
    do_read(BASE + 32'h50, 8'd2, 2'b00, 1'b0, -1, d);
    do_write(BASE + 32'h1A8, 8'd7, 2'b10, '0, 1'b1, '1, 1'b0, 7);
    do_read(BASE + 32'h180, 8'd7, 2'b01, 1'b0, -1, d);
    do_read(BASE + 32'h1A0, 8'd2, 2'b10, 1'b0, -1, d);
    do_read(BASE + 32'h1A0, 8'd3, 2'b11, 1'b0, -1, d);

    // WLAST early and WLAST never asserted
    do_write(BASE + 32'h60, 8'd2, 2'b01, '0, 1'b1, '1, 1'b0, 0);
    do_write(BASE + 32'h60, 8'd2, 2'b01, '0, 1'b1, '1, 1'b0, -1);
    do_read(BASE + 32'h60, 8'd2, 2'b01, 1'b0, -1, d);

    // Read back-pressure with an independent write running alongside
    fork
      do_read(BASE, 8'd7, 2'b01, 1'b1, -1, d);
      do_write(BASE + 32'h200, 8'd3, 2'b01, '0, 1'b1, '1, 1'b1, 3);
    join
    do_read(BASE + 32'h200, 8'd3, 2'b01, 1'b0, -1, d);

    // Random write-then-readback bursts
    for (int k = 0; k < 20; k++) begin
      bt  = 2'($urandom);
      len = (bt == 2'b10) ? 8'((1 << $urandom_range(1, 3)) - 1) : 8'($urandom_range(0, 7));
      a   = BASE + 32'($urandom_range(0, DEPTH + 3)) * BYTES + 32'($urandom_range(0, BYTES - 1));
      do_write(a, len, bt, '0, 1'b1, '0, 1'b1, int'(len));
      do_read(a, len, bt, 1'b0, -1, d);
    end

    // Reset in the middle of a read burst, then confirm memory survived
    do_read(BASE, 8'd7, 2'b01, 1'b0, 2, d);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("mid_burst_reset");
    @(negedge clk);
    rstn = 1'b1;
    do_read(BASE, 8'd7, 2'b01, 1'b0, -1, d);
    do_read(BASE + 32'h20, 8'd0, 2'b01, 1'b0, -1, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
